mic_frame_packer: RTL and testbench
===================================

Name: mic_frame_packer

Overview:
- Upstream producer for the 32x256 ping-pong frame buffer.
- Packs pairs of 16-bit PCM microphone samples into 32-bit words and writes them sequentially to word addresses 0..255 of the buffer's write side.
- When the frame is full, raises writeDone and holds it until the buffer pulses goodToGo, then starts the next frame at address 0.
- Samples arriving while it waits for the swap are dropped and counted.

Parameters:
- DEPTH, 256, words per frame; the last word address is DEPTH-1.
- AW, 8, address width; must satisfy 2^AW = DEPTH.
- SW, 16, input sample width.
- DW, 32, buffer word width; fixed at 2*SW.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  SW  PCM sample, valid when s_valid=1.
- s_valid  in  1  one-cycle strobe per sample; no backpressure.
- w_addr  out  AW  buffer write address (registered).
- w_data  out  DW  buffer write data (registered).
- wren  out  1  buffer write enable, single-cycle pulse (registered).
- writeDone  out  1  frame complete; held high until goodToGo is seen (registered).
- goodToGo  in  1  one-cycle swap pulse from the ping-pong buffer.
- frame_cnt  out  16  frames completed and handed off; wraps 0xFFFF->0.
- drop_cnt  out  16  samples dropped while in WAIT; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release):
  - State FILL; phase=0; word index=0.
  - w_addr=0, w_data=0, wren=0, writeDone=0, frame_cnt=0, drop_cnt=0.
- Reset mid-frame: any partial frame is abandoned and the next frame restarts at address 0.
  - The buffer side is not reset; the reader of the stale half must tolerate this.
- State FILL:
  - s_valid with phase=0: latch s_data into the low-half register; phase<=1; no write.
  - s_valid with phase=1, at the clock edge:
    - w_data<={s_data, low_half}, so the first sample lands in bits [15:0] and the second in [31:16].
    - w_addr<=index; wren<=1 for exactly one cycle; phase<=0; index<=index+1.
  - Latency: wren is high in the cycle immediately after the second sample's s_valid cycle.
  - Without a write, wren<=0; w_addr and w_data hold their last values.
  - Write of index DEPTH-1: on the same edge, writeDone<=1, state<=WAIT, index wraps to 0.
    - writeDone therefore rises in the same cycle as the final wren. This is legal: the buffer swap happens no earlier than the following edge, so the last word lands in the current write half.
  - goodToGo in FILL is ignored. The buffer powers up in a switch state and pulses goodToGo once after reset.
- State WAIT:
  - writeDone=1, wren=0.
  - Each s_valid cycle increments drop_cnt (saturating); the sample is discarded.
  - goodToGo=1 sampled at an edge:
    - writeDone<=0, state<=FILL, phase<=0, index<=0, frame_cnt<=frame_cnt+1.
    - writeDone is low from the first cycle after the swap pulse, so the buffer cannot double-switch.
  - s_valid coinciding with the goodToGo cycle: the sample is dropped and counted. The first sample of the new frame is the next s_valid after that cycle.
- s_valid held high continuously is legal: one sample per cycle, one write every 2 cycles.
- No other states. Any illegal state encoding recovers to FILL with index=0.

Test Plan:
- Reset, then samples 0x0001, 0x0002 on consecutive cycles -> next cycle wren=1, w_addr=0x00, w_data=0x00020001; following cycle wren=0.
- Drive 512 samples of value n=0..511 -> 256 wren pulses at addresses 0..255 with w_data[15:0]=2k and [31:16]=2k+1. writeDone rises in the same cycle as the addr 0xFF write. frame_cnt=0 until the handoff.
- In WAIT, drive 5 samples, then pulse goodToGo together with a 6th sample -> drop_cnt=6, frame_cnt=1, writeDone=0 next cycle. Next two samples are written to addr 0x00.
- Pulse goodToGo at random times during FILL (including right after reset) -> no effect on index, writeDone or frame_cnt.
- Assert rst_n=0 mid-frame after 101 samples (index 50, phase=1) -> all outputs 0 immediately. After release, samples 0xAAAA, 0x5555 produce a write at addr 0x00 with data 0x5555AAAA.
- Hold WAIT for 70000 s_valid cycles -> drop_cnt saturates at 0xFFFF. frame_cnt wraps from 0xFFFF to 0x0000 after 65536 handoffs (forced/short-DEPTH build allowed).

Source files
------------

// File: rtl/mic_frame_packer.sv
// +--------------------------------------------------------------------------+
// | mic_frame_packer: packs 16-bit PCM sample pairs into frame words  rev 1.0|
// +--------------------------------------------------------------------------+
`default_nettype none

module mic_frame_packer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int SW    = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] s_data,
  input  logic          s_valid,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          wren,
  output logic          writeDone,
  input  logic          goodToGo,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [1:0] {
    ST_FILL = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic [AW-1:0] index_q, index_d;
  logic [SW-1:0] low_q, low_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic          wren_q, wren_d;
  logic          done_q, done_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      phase_q     <= 1'b0;
      index_q     <= '0;
      low_q       <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      wren_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      index_q     <= index_d;
      low_q       <= low_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      wren_q      <= wren_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    index_d     = index_q;
    low_d       = low_q;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    wren_d      = 1'b0;
    done_d      = done_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      ST_FILL: begin
        if (s_valid) begin
          if (!phase_q) begin
            low_d   = s_data;
            phase_d = 1'b1;
          end else begin
            w_data_d = {s_data, low_q};
            w_addr_d = index_q;
            wren_d   = 1'b1;
            phase_d  = 1'b0;
            // Last word: hand off on the same edge so writeDone rises with the final wren.
            if (index_q == AW'(DEPTH - 1)) begin
              index_d = '0;
              done_d  = 1'b1;
              state_d = ST_WAIT;
            end else begin
              index_d = index_q + AW'(1);
            end
          end
        end
      end
      ST_WAIT: begin
        if (s_valid && (drop_cnt_q != 16'hFFFF)) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (goodToGo) begin
          done_d      = 1'b0;
          state_d     = ST_FILL;
          phase_d     = 1'b0;
          index_d     = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_FILL;
        phase_d = 1'b0;
        index_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign wren      = wren_q;
  assign writeDone = done_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mic_frame_packer.sv
// Bench for mic_frame_packer: queue-based frame model plus pinned literal expectations.
`default_nettype none

module tb_mic_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        goodToGo = 1'b0;
  logic [7:0]  w_addr;
  logic [31:0] w_data;
  logic        wren;
  logic        writeDone;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  mic_frame_packer #(.DEPTH(256), .AW(8), .SW(16), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .w_addr(w_addr), .w_data(w_data), .wren(wren), .writeDone(writeDone),
    .goodToGo(goodToGo), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference: samples collect in a queue; every two form a word at the next address in the frame.
  logic [15:0] pend[$];
  int          m_words = 0;
  bit          m_wait = 0;
  logic [7:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_wren = 1'b0;
  logic        exp_done = 1'b0;
  logic [15:0] exp_frame = '0;
  logic [15:0] exp_drop = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pend.delete();
      m_words = 0; m_wait = 0;
      exp_addr = '0; exp_data = '0; exp_wren = 1'b0; exp_done = 1'b0;
      exp_frame = '0; exp_drop = '0;
    end else begin
      exp_wren = 1'b0;
      if (m_wait) begin
        if (s_valid && exp_drop < 16'hFFFF) exp_drop = exp_drop + 16'd1;
        if (goodToGo) begin
          m_wait = 0; exp_done = 1'b0; m_words = 0; pend.delete();
          exp_frame = exp_frame + 16'd1;
        end
      end else if (s_valid) begin
        pend.push_back(s_data);
        if (pend.size() == 2) begin
          exp_data = {pend[1], pend[0]};
          exp_addr = 8'(m_words % 256);
          exp_wren = 1'b1;
          pend.delete();
          m_words++;
          if (m_words == 256) begin
            m_wait = 1; exp_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("m_wren", {31'd0, wren}, {31'd0, exp_wren});
    chk("m_addr", {24'd0, w_addr}, {24'd0, exp_addr});
    chk("m_data", w_data, exp_data);
    chk("m_done", {31'd0, writeDone}, {31'd0, exp_done});
    chk("m_frame", {16'd0, frame_cnt}, {16'd0, exp_frame});
    chk("m_drop", {16'd0, drop_cnt}, {16'd0, exp_drop});
  end

  task automatic step(input logic v, input logic [15:0] d, input logic g);
    @(negedge clk);
    s_valid = v; s_data = d; goodToGo = g;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, {24'd0, w_addr}, 32'd0);
    chk({tag, "_data"}, w_data, 32'd0);
    chk({tag, "_wren"}, {31'd0, wren}, 32'd0);
    chk({tag, "_done"}, {31'd0, writeDone}, 32'd0);
    chk({tag, "_frame"}, {16'd0, frame_cnt}, 32'd0);
    chk({tag, "_drop"}, {16'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    #1 chk_zero("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // goodToGo right after reset is ignored in FILL
    step(0, 16'h0, 1);
    step(1, 16'h0001, 0);
    step(1, 16'h0002, 0);
    step(0, 16'h0, 0);
    chk("first_wren", {31'd0, wren}, 32'd1);
    chk("first_addr", {24'd0, w_addr}, 32'h0);
    chk("first_data", w_data, 32'h00020001);
    chk("first_frame", {16'd0, frame_cnt}, 32'd0);
    step(0, 16'h0, 0);
    chk("first_wren_off", {31'd0, wren}, 32'd0);

    // Restart and fill a full frame with a ramp, random goodToGo noise
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 512; n++) begin
      step(1, 16'(n), ($urandom_range(0, 7) == 0));
      if (n == 2) begin
        chk("ramp_w0_data", w_data, 32'h00010000);
        chk("ramp_w0_wren", {31'd0, wren}, 32'd1);
      end
    end
    step(0, 16'h0, 0);
    chk("last_wren", {31'd0, wren}, 32'd1);
    chk("last_addr", {24'd0, w_addr}, 32'hFF);
    chk("last_data", w_data, 32'h01FF01FE);
    chk("last_done", {31'd0, writeDone}, 32'd1);
    chk("last_frame", {16'd0, frame_cnt}, 32'd0);

    // Drops in WAIT, handoff coinciding with a sample
    for (int i = 0; i < 5; i++) step(1, 16'($urandom), 0);
    step(1, 16'hBEEF, 1);
    step(0, 16'h0, 0);
    chk("hand_done", {31'd0, writeDone}, 32'd0);
    chk("hand_drop", {16'd0, drop_cnt}, 32'd6);
    chk("hand_frame", {16'd0, frame_cnt}, 32'd1);
    step(1, 16'h1111, 0);
    step(1, 16'h2222, 0);
    step(0, 16'h0, 0);
    chk("new_addr", {24'd0, w_addr}, 32'h0);
    chk("new_data", w_data, 32'h22221111);
    chk("new_wren", {31'd0, wren}, 32'd1);

    // Random traffic: sparse/dense samples and random swap pulses
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 31) == 0));

    // Reset in the middle of a frame (index 50, phase 1)
    step(0, 16'h0, 0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 101; n++) step(1, 16'(n + 7), 0);
    step(0, 16'h0, 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk); rst_n = 1'b1;
    step(1, 16'hAAAA, 0);
    step(1, 16'h5555, 0);
    step(0, 16'h0, 0);
    chk("post_addr", {24'd0, w_addr}, 32'h0);
    chk("post_data", w_data, 32'h5555AAAA);
    chk("post_wren", {31'd0, wren}, 32'd1);

    // Complete the frame, then saturate the drop counter
    for (int n = 0; n < 510; n++) step(1, 16'(n), 0);
    for (int i = 0; i < 70000; i++) step(1, 16'($urandom), 0);
    step(0, 16'h0, 0);
    chk("sat_drop", {16'd0, drop_cnt}, 32'hFFFF);
    chk("sat_done", {31'd0, writeDone}, 32'd1);
    step(0, 16'h0, 1);
    step(0, 16'h0, 0);
    chk("sat_frame", {16'd0, frame_cnt}, 32'd1);
    chk("sat_done_clr", {31'd0, writeDone}, 32'd0);
    chk("sat_drop_hold", {16'd0, drop_cnt}, 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
